axi4_lite_slave_regfile: RTL and testbench

AXI4_LITE_SLAVE_REGFILE -- requirements
Module: axi4_lite_slave_regfile

---
 rtl/axi4_lite_slave_regfile.sv | 144 ++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers, also visible as a flat output bus.
// The read and write channels run independently; the write path holds AW and W in separate slots.
module axi4_lite_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr_in,
    input  logic [2:0]                     awprot_in,
    input  logic                           awvalid_in,
    output logic                           awready_out,
    input  logic [DATA_WIDTH-1:0]          wdata_in,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_in,
    input  logic                           wvalid_in,
    output logic                           wready_out,
    output logic [1:0]                     bresp_out,
    output logic                           bvalid_out,
    input  logic                           bready_in,
    input  logic [ADDR_WIDTH-1:0]          araddr_in,
    input  logic [2:0]                     arprot_in,
    input  logic                           arvalid_in,
    output logic                           arready_out,
    output logic [DATA_WIDTH-1:0]          rdata_out,
    output logic [1:0]                     rresp_out,
    output logic                           rvalid_out,
    input  logic                           rready_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_SHIFT = $clog2(STRB_WIDTH);
    localparam int SEL_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] REG_COUNT = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  init_done;
    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic [ADDR_WIDTH-1:0] aw_index;
    logic [ADDR_WIDTH-1:0] ar_index;
    logic [SEL_WIDTH-1:0]  aw_sel;
    logic [SEL_WIDTH-1:0]  ar_sel;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;

    wire unused_prot = ^{awprot_in, arprot_in};

    assign awready_out = init_done & ~aw_full & ~bvalid_out;
    assign wready_out  = init_done & ~w_full & ~bvalid_out;
    assign arready_out = init_done & ~rvalid_out;

    assign aw_hs  = awvalid_in & awready_out;
    assign w_hs   = wvalid_in & wready_out;
    assign ar_hs  = arvalid_in & arready_out;
    assign commit = aw_full & w_full;

    assign aw_index    = aw_addr_q >> ADDR_SHIFT;
    assign ar_index    = araddr_in >> ADDR_SHIFT;
    assign aw_in_range = aw_index < REG_COUNT;
    assign ar_in_range = ar_index < REG_COUNT;
    assign aw_sel      = aw_index[SEL_WIDTH-1:0];
    assign ar_sel      = ar_index[SEL_WIDTH-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Write path: slots fill independently and commit together on the edge after both are full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_out <= 1'b0;
            bresp_out  <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr_in;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= wdata_in;
                w_strb_q <= wstrb_in;
            end
            if (commit) begin
                aw_full    <= 1'b0;
                w_full     <= 1'b0;
                bvalid_out <= 1'b1;
                bresp_out  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                if (aw_in_range) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb_q[b]) begin
                            regs[aw_sel][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                end
            end else if (bvalid_out && bready_in) begin
                bvalid_out <= 1'b0;
            end
        end
    end

    // Read path samples the pre-commit register value because the write lands in the same NBA update.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_out <= 1'b0;
            rdata_out  <= '0;
            rresp_out  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_out <= 1'b1;
            rdata_out  <= ar_in_range ? regs[ar_sel] : '0;
            rresp_out  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_out && rready_in) begin
            rvalid_out <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed, table-driven bench for axi4_lite_slave_regfile (32-bit data, 8 registers).
module tb_axi4_lite_slave_regfile;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  awaddr_in;
    logic [2:0]   awprot_in;
    logic         awvalid_in;
    logic         awready_out;
    logic [31:0]  wdata_in;
    logic [3:0]   wstrb_in;
    logic         wvalid_in;
    logic         wready_out;
    logic [1:0]   bresp_out;
    logic         bvalid_out;
    logic         bready_in;
    logic [31:0]  araddr_in;
    logic [2:0]   arprot_in;
    logic         arvalid_in;
    logic         arready_out;
    logic [31:0]  rdata_out;
    logic [1:0]   rresp_out;
    logic         rvalid_out;
    logic         rready_in;
    logic [255:0] regs_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    axi4_lite_slave_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_REGS  (8)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .awaddr_in  (awaddr_in),
        .awprot_in  (awprot_in),
        .awvalid_in (awvalid_in),
        .awready_out(awready_out),
        .wdata_in   (wdata_in),
        .wstrb_in   (wstrb_in),
        .wvalid_in  (wvalid_in),
        .wready_out (wready_out),
        .bresp_out  (bresp_out),
        .bvalid_out (bvalid_out),
        .bready_in  (bready_in),
        .araddr_in  (araddr_in),
        .arprot_in  (arprot_in),
        .arvalid_in (arvalid_in),
        .arready_out(arready_out),
        .rdata_out  (rdata_out),
        .rresp_out  (rresp_out),
        .rvalid_out (rvalid_out),
        .rready_in  (rready_in),
        .regs_out   (regs_out)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [31:0] reg_of(input int k);
        return regs_out[k*32 +: 32];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Issues AW and W together, drops each valid after its own handshake, then collects the response.
    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int cycles;
        logic aw_go;
        logic w_go;
        @(negedge aclk);
        awaddr_in  = addr;
        wdata_in   = data;
        wstrb_in   = strb;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        bready_in  = 1'b1;
        cycles = 0;
        while ((awvalid_in || wvalid_in) && cycles < 20) begin
            aw_go = awvalid_in && awready_out;
            w_go  = wvalid_in && wready_out;
            @(posedge aclk);
            #1;
            if (aw_go) awvalid_in = 1'b0;
            if (w_go) wvalid_in = 1'b0;
            cycles++;
            @(negedge aclk);
        end
        if (awvalid_in || wvalid_in) begin
            report_timeout("write_addr_data_handshake");
            awvalid_in = 1'b0;
            wvalid_in  = 1'b0;
        end
        cycles = 0;
        while (!bvalid_out && cycles < 20) begin
            @(negedge aclk);
            cycles++;
        end
        if (!bvalid_out) begin
            report_timeout("write_response");
            resp = 2'b11;
        end else begin
            resp = bresp_out;
            @(posedge aclk);
            #1;
        end
        bready_in = 1'b0;
    endtask

    task automatic apply_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cycles;
        @(negedge aclk);
        araddr_in  = addr;
        arvalid_in = 1'b1;
        rready_in  = 1'b1;
        cycles = 0;
        while (!arready_out && cycles < 20) begin
            @(negedge aclk);
            cycles++;
        end
        if (!arready_out) begin
            report_timeout("read_addr_handshake");
        end
        @(posedge aclk);
        #1;
        arvalid_in = 1'b0;
        cycles = 0;
        @(negedge aclk);
        while (!rvalid_out && cycles < 20) begin
            @(negedge aclk);
            cycles++;
        end
        if (!rvalid_out) begin
            report_timeout("read_response");
            data = 32'hxxxx_xxxx;
            resp = 2'b11;
        end else begin
            data = rdata_out;
            resp = rresp_out;
            @(posedge aclk);
            #1;
        end
        rready_in = 1'b0;
    endtask

    // Runs one table vector through the matching channel task and compares against its expectations.
    task automatic apply_stimulus(input int idx);
        logic [1:0]  resp;
        logic [31:0] data;
        if (vecs[idx].is_write) begin
            apply_write(vecs[idx].addr, vecs[idx].data, vecs[idx].strb, resp);
            check_output($sformatf("vec%0d_bresp", idx), {30'd0, resp}, {30'd0, vecs[idx].exp_resp});
        end else begin
            apply_read(vecs[idx].addr, data, resp);
            check_output($sformatf("vec%0d_rresp", idx), {30'd0, resp}, {30'd0, vecs[idx].exp_resp});
            check_output($sformatf("vec%0d_rdata", idx), data, vecs[idx].exp_rdata);
        end
    endtask

    initial begin
        logic [31:0] final_regs [8];

        vecs[0]  = '{1'b0, 32'd16, 32'h0,         4'h0, 2'b00, 32'hF000A596};
        vecs[1]  = '{1'b1, 32'd0,  32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 32'd0,  32'h0,         4'h0, 2'b00, 32'h11223344};
        vecs[3]  = '{1'b1, 32'd4,  32'hAABBCCDD, 4'h1, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'd4,  32'h0,         4'h0, 2'b00, 32'h000000DD};
        vecs[5]  = '{1'b1, 32'd28, 32'hDEADBEEF, 4'hC, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 32'd28, 32'h0,         4'h0, 2'b00, 32'hDEAD0000};
        vecs[7]  = '{1'b1, 32'd64, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 32'd64, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 32'd17, 32'h0,         4'h0, 2'b00, 32'hF000A596};
        vecs[10] = '{1'b1, 32'd30, 32'h12345678, 4'h3, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'd28, 32'h0,         4'h0, 2'b00, 32'hDEAD5678};
        vecs[12] = '{1'b1, 32'd100, 32'h0BADF00D, 4'hF, 2'b10, 32'h0};
        vecs[13] = '{1'b0, 32'd8,  32'h0,         4'h0, 2'b00, 32'h12345678};

        final_regs = '{32'h11223344, 32'h000000DD, 32'h12345678, 32'h0,
                       32'h55555555, 32'h0, 32'h0, 32'hDEAD5678};

        aresetn    = 1'b0;
        awaddr_in  = '0;
        awprot_in  = '0;
        awvalid_in = 1'b0;
        wdata_in   = '0;
        wstrb_in   = '0;
        wvalid_in  = 1'b0;
        bready_in  = 1'b0;
        araddr_in  = '0;
        arprot_in  = '0;
        arvalid_in = 1'b0;
        rready_in  = 1'b0;

        // Reset and first-cycle ready behaviour.
        repeat (3) @(negedge aclk);
        check_output("reset_readies", {29'd0, awready_out, wready_out, arready_out}, 32'd0);
        check_output("reset_valids", {30'd0, bvalid_out, rvalid_out}, 32'd0);
        check_output("reset_regs", {31'd0, |regs_out}, 32'd0);
        check_output("reset_rdata", rdata_out, 32'd0);
        aresetn = 1'b1;
        #1;
        check_output("release_readies_still_low", {29'd0, awready_out, wready_out, arready_out}, 32'd0);
        @(negedge aclk);
        check_output("idle_readies", {29'd0, awready_out, wready_out, arready_out}, 32'd7);

        // Aligned write with strobe 1011 and exact one-cycle commit latency.
        awaddr_in  = 32'd16;
        wdata_in   = 32'hF0B4A596;
        wstrb_in   = 4'b1011;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        bready_in  = 1'b0;
        @(posedge aclk);
        #1;
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        @(negedge aclk);
        check_output("aligned_bvalid_not_early", {31'd0, bvalid_out}, 32'd0);
        check_output("aligned_slots_block", {30'd0, awready_out, wready_out}, 32'd0);
        check_output("aligned_reg4_not_early", reg_of(4), 32'd0);
        @(negedge aclk);
        check_output("aligned_bvalid", {31'd0, bvalid_out}, 32'd1);
        check_output("aligned_bresp", {30'd0, bresp_out}, 32'd0);
        check_output("aligned_reg4", reg_of(4), 32'hF000A596);
        @(negedge aclk);
        check_output("aligned_bvalid_held", {31'd0, bvalid_out}, 32'd1);
        bready_in = 1'b1;
        @(negedge aclk);
        check_output("aligned_bvalid_cleared", {31'd0, bvalid_out}, 32'd0);
        bready_in = 1'b0;

        // Split write: W first, AW three cycles later.
        wdata_in  = 32'h12345678;
        wstrb_in  = 4'hF;
        wvalid_in = 1'b1;
        @(posedge aclk);
        #1;
        wvalid_in = 1'b0;
        @(negedge aclk);
        check_output("split_wready_dropped", {31'd0, wready_out}, 32'd0);
        check_output("split_awready_open", {31'd0, awready_out}, 32'd1);
        @(negedge aclk);
        @(negedge aclk);
        awaddr_in  = 32'd8;
        awvalid_in = 1'b1;
        @(posedge aclk);
        #1;
        awvalid_in = 1'b0;
        @(negedge aclk);
        check_output("split_bvalid_not_early", {31'd0, bvalid_out}, 32'd0);
        @(negedge aclk);
        check_output("split_reg2", reg_of(2), 32'h12345678);
        check_output("split_bvalid", {31'd0, bvalid_out}, 32'd1);
        bready_in = 1'b1;
        @(negedge aclk);
        bready_in = 1'b0;

        // Read backpressure: response held for five cycles with rready low.
        araddr_in  = 32'd8;
        arvalid_in = 1'b1;
        rready_in  = 1'b0;
        @(posedge aclk);
        #1;
        arvalid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_output($sformatf("bp_rvalid_%0d", i), {31'd0, rvalid_out}, 32'd1);
            check_output($sformatf("bp_rdata_%0d", i), rdata_out, 32'h12345678);
            check_output($sformatf("bp_arready_%0d", i), {31'd0, arready_out}, 32'd0);
        end
        rready_in = 1'b1;
        @(negedge aclk);
        check_output("bp_rvalid_cleared", {31'd0, rvalid_out}, 32'd0);
        check_output("bp_arready_back", {31'd0, arready_out}, 32'd1);
        rready_in = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i);
        end

        // Read of reg4 sampled on the same edge the new reg4 value commits.
        @(negedge aclk);
        awaddr_in  = 32'd16;
        wdata_in   = 32'h55555555;
        wstrb_in   = 4'hF;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        bready_in  = 1'b0;
        @(posedge aclk);
        #1;
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        @(negedge aclk);
        araddr_in  = 32'd16;
        arvalid_in = 1'b1;
        rready_in  = 1'b0;
        @(posedge aclk);
        #1;
        arvalid_in = 1'b0;
        @(negedge aclk);
        check_output("conc_rvalid", {31'd0, rvalid_out}, 32'd1);
        check_output("conc_old_value", rdata_out, 32'hF000A596);
        check_output("conc_bvalid", {31'd0, bvalid_out}, 32'd1);
        check_output("conc_reg4_new", reg_of(4), 32'h55555555);
        bready_in = 1'b1;
        rready_in = 1'b1;
        @(negedge aclk);
        bready_in = 1'b0;
        rready_in = 1'b0;

        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("final_reg%0d", k), reg_of(k), final_regs[k]);
        end

        // Reset while a write response is pending.
        awaddr_in  = 32'd0;
        wdata_in   = 32'hCAFEF00D;
        wstrb_in   = 4'hF;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        @(posedge aclk);
        #1;
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check_output("pending_bvalid", {31'd0, bvalid_out}, 32'd1);
        aresetn = 1'b0;
        #1;
        check_output("midreset_bvalid", {31'd0, bvalid_out}, 32'd0);
        check_output("midreset_readies", {29'd0, awready_out, wready_out, arready_out}, 32'd0);
        check_output("midreset_regs", {31'd0, |regs_out}, 32'd0);
        @(negedge aclk);
        aresetn   = 1'b1;
        bready_in = 1'b1;
        @(negedge aclk);
        check_output("postreset_readies", {29'd0, awready_out, wready_out, arready_out}, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check_output($sformatf("postreset_no_resp_%0d", i), {31'd0, bvalid_out}, 32'd0);
        end
        check_output("postreset_reg0", reg_of(0), 32'd0);
        bready_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
